image_frame_sequencer: RTL and testbench
========================================

Name: image_frame_sequencer

Overview:
Sequences one frame of 2-pixel-pair reads through the image processing datapath. It generates row/col indices, the line-active strobe (HSYNC) and inter-line blanking, and applies ready/valid backpressure from the downstream writer. It latches the processing mode once per frame so the datapath never changes operation mid-frame. It sits between the top-level start/control logic and the pixel memory/processing datapath.

Parameters:
WIDTH, 768, pixels per line; must be even and ≥ 2.
HEIGHT, 512, lines per frame; must be ≥ 1.
HBLANK, 4, idle cycles between lines; 0 is allowed (no blank state).
ROW_W, 10, row index width.
COL_W, 11, col index width.
CNT_W, 18, width of the accepted-pair counter; must hold WIDTH*HEIGHT/2.

Ports:
HCLK  in  1  clock; all logic is on the rising edge.
HRESETn  in  1  reset; synchronous, active-low.
start  in  1  frame request pulse; honoured only in IDLE.
abort  in  1  synchronous abort; returns the block to IDLE.
mode_in  in  2  operation: 00 bypass, 01 brightness, 10 invert, 11 threshold.
pix_ready  in  1  downstream accepts the current pair.
pix_valid  out  1  current row/col pair is valid.
row  out  ROW_W  current line index.
col  out  COL_W  even column of the current pair; the pair covers col and col+1.
HSYNC  out  1  high while in LINE.
line_last  out  1  pix_valid and col==WIDTH-2.
frame_last  out  1  line_last and row==HEIGHT-1.
mode_q  out  2  mode latched at frame start.
busy  out  1  state != IDLE.
pair_count  out  CNT_W  pairs accepted in the current frame.
ctrl_done  out  1  one-cycle frame-complete pulse.
start_err  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (HRESETn==0 at a clock edge):
  - state = IDLE.
  - All outputs 0: row, col, pair_count, mode_q, pix_valid, HSYNC, ctrl_done, start_err.
- States: IDLE, LINE, BLANK, DONE. All outputs are Moore or registered; there is no combinational path from pix_ready to pix_valid.
- IDLE:
  - On start: latch mode_q = mode_in, clear row/col/pair_count, go to LINE.
  - Otherwise stay in IDLE.
- LINE:
  - pix_valid = 1 and HSYNC = 1.
  - A transfer occurs on pix_valid & pix_ready. On a transfer, pair_count increments.
  - row, col and pix_valid must stay stable while pix_ready is low.
  - Transfer with col < WIDTH-2: col += 2.
  - Transfer with col == WIDTH-2:
    - col = 0.
    - If row == HEIGHT-1: go to DONE.
    - Else if HBLANK > 0: go to BLANK and load the blank counter with HBLANK-1.
    - Else: row += 1 and stay in LINE.
- BLANK:
  - pix_valid = 0 and HSYNC = 0.
  - The counter decrements each cycle. When it reads 0: row += 1, go to LINE.
  - Exactly HBLANK cycles are spent in BLANK.
- DONE:
  - ctrl_done = 1 for exactly one cycle, then go to IDLE.
  - row/col/pair_count hold their final values until the next start.
- abort:
  - Highest priority after reset. In any state, the next state is IDLE.
  - No ctrl_done pulse; pair_count holds its value.
  - abort and start together in IDLE: abort wins and the block stays in IDLE.
- start while busy: ignored, and start_err pulses 1 cycle. start in the DONE cycle is also ignored, with start_err.
- Latency:
  - start at edge N gives pix_valid at edge N+1.
  - The last accepted transfer gives ctrl_done on the next cycle.
  - Minimum frame length with pix_ready tied high: WIDTH*HEIGHT/2 + (HEIGHT-1)*HBLANK LINE/BLANK cycles, plus 1 DONE cycle.
- Widths and arithmetic:
  - Comparisons use parameter values truncated to the port widths.
  - pair_count never wraps within a legal frame.
  - Defaults: final pair_count = 196608.
- mode_in changes mid-frame have no effect on mode_q.

Decomposition:
- Shared package image_pkg holds:
  - the state encoding (IDLE/LINE/BLANK/DONE);
  - mode codes MODE_BYPASS, MODE_BRIGHT, MODE_INVERT, MODE_THRESH;
  - default WIDTH/HEIGHT constants.
- One natural sub-module, image_pos_counter: the row/col pair stepper with wrap and line_last/frame_last flags.
- The FSM, blank counter and pulses stay in the top module.

Test Plan:
- WIDTH=8, HEIGHT=4, HBLANK=2, pix_ready=1, start at cycle 0:
  - pix_valid in cycles 1-4, 7-10, 13-16 and 19-22.
  - HSYNC low in cycles 5-6, 11-12 and 17-18.
  - ctrl_done only in cycle 23; pair_count = 16.
- Same configuration, pix_ready low on every other cycle: row/col stable while stalled; each (row, col) pair appears accepted exactly once; ctrl_done one cycle after the 16th transfer.
- HBLANK=0, WIDTH=4, HEIGHT=2: row changes 0→1 with no pix_valid gap; ctrl_done in cycle 5.
- mode_in=11 at start, changed to 01 mid-frame: mode_q stays 11 for the whole frame; the next start latches 01.
- abort during the second line: busy=0 next cycle, no ctrl_done, pair_count frozen at 5 for a transfer count of 5.
- Corner cases:
  - start during LINE → start_err pulse, frame unaffected.
  - HRESETn low mid-frame → every output 0 on the next edge.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the image frame sequencer: FSM state encoding,
// processing-mode codes and default frame geometry.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_BRIGHT = 2'b01,
    MODE_INVERT = 2'b10,
    MODE_THRESH = 2'b11
  } mode_e;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_HBLANK = 4;

endpackage

// File: rtl/image_pos_counter.sv
// Row/column stepper for pixel pairs: col advances by 2 and wraps at the
// end of a line; row advances on request. Also flags the last pair of a line/frame.
module image_pos_counter
  import image_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic             i_row_inc,
  input  logic             i_valid,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_line_last,
  output logic             o_frame_last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_col_end;

  assign w_col_end = (r_col == COL_LAST);

  // NOTE: non-blocking assignments for every register, so all flops sample pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      if (i_step)    r_col <= w_col_end ? '0 : r_col + COL_W'(2);
      if (i_row_inc) r_row <= r_row + ROW_W'(1);
    end
  end

  assign o_row        = r_row;
  assign o_col        = r_col;
  assign o_line_last  = i_valid & w_col_end;
  assign o_frame_last = o_line_last & (r_row == ROW_LAST);

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame sequencer: walks one frame of pixel pairs with line blanking, honours
// downstream backpressure and freezes the processing mode for the whole frame.
module image_frame_sequencer
  import image_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int HBLANK = DEF_HBLANK,
  parameter int ROW_W  = 10,
  parameter int COL_W  = 11,
  parameter int CNT_W  = 18
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode_in,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             HSYNC,
  output logic             line_last,
  output logic             frame_last,
  output logic [1:0]       mode_q,
  output logic             busy,
  output logic [CNT_W-1:0] pair_count,
  output logic             ctrl_done,
  output logic             start_err
);

  localparam int               BLK_W     = (HBLANK > 2) ? $clog2(HBLANK) : 1;
  localparam logic [BLK_W-1:0] BLK_LOAD  = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam bit               HAS_BLANK = (HBLANK > 0);

  state_e           r_state, w_state_next;
  logic [BLK_W-1:0] r_blank_cnt;
  logic [CNT_W-1:0] r_pair_count;
  mode_e            r_mode_q;
  logic             r_start_err;

  logic             w_pix_valid, w_xfer, w_start_ok, w_blank_end, w_row_inc;
  logic             w_line_last, w_frame_last;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;

  // Abort suppresses any transfer or row step in the same cycle so counts freeze.
  assign w_pix_valid = (r_state == LINE);
  assign w_xfer      = w_pix_valid & pix_ready & ~abort;
  assign w_start_ok  = (r_state == IDLE) & start & ~abort;
  assign w_blank_end = (r_state == BLANK) & (r_blank_cnt == '0) & ~abort;
  assign w_row_inc   = (w_xfer & w_line_last & ~w_frame_last & ~HAS_BLANK) | w_blank_end;

  image_pos_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pos (
    .i_clk       (HCLK),
    .i_rst_n     (HRESETn),
    .i_clear     (w_start_ok),
    .i_step      (w_xfer),
    .i_row_inc   (w_row_inc),
    .i_valid     (w_pix_valid),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_line_last (w_line_last),
    .o_frame_last(w_frame_last)
  );

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (start) w_state_next = LINE;
      LINE: begin
        if (w_xfer && w_line_last) begin
          if (w_frame_last)   w_state_next = DONE;
          else if (HAS_BLANK) w_state_next = BLANK;
        end
      end
      BLANK: if (r_blank_cnt == '0) w_state_next = LINE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (abort) w_state_next = IDLE;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state      <= IDLE;
      r_blank_cnt  <= '0;
      r_pair_count <= '0;
      r_mode_q     <= MODE_BYPASS;
      r_start_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_start_err <= start & (r_state != IDLE);
      if (w_start_ok) begin
        r_mode_q     <= mode_e'(mode_in);
        r_pair_count <= '0;
      end else if (w_xfer) begin
        r_pair_count <= r_pair_count + CNT_W'(1);
      end
      if (w_xfer && w_line_last)
        r_blank_cnt <= BLK_LOAD;
      else if (r_state == BLANK && r_blank_cnt != '0)
        r_blank_cnt <= r_blank_cnt - BLK_W'(1);
    end
  end

  assign pix_valid  = w_pix_valid;
  assign HSYNC      = w_pix_valid;
  assign row        = w_row;
  assign col        = w_col;
  assign line_last  = w_line_last;
  assign frame_last = w_frame_last;
  assign mode_q     = r_mode_q;
  assign busy       = (r_state != IDLE);
  assign pair_count = r_pair_count;
  assign ctrl_done  = (r_state == DONE);
  assign start_err  = r_start_err;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Scoreboard bench for image_frame_sequencer: a frame model queues the expected
// pair sequence; a monitor pops and compares on every accepted transfer.
module tb_image_frame_sequencer;

  localparam int W  = 8, H  = 4, HB  = 2;
  localparam int BW = 4, BH = 2, BHB = 0;
  localparam int DONE_A = H * W / 2 + (H - 1) * HB + 1;
  localparam int DONE_B = BH * BW / 2 + (BH - 1) * BHB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, abort_a, ready_a, start_b, abort_b, ready_b;
  logic [1:0]  mode_a, mode_b;

  logic        a_pix_valid, a_hsync, a_line_last, a_frame_last, a_busy, a_ctrl_done, a_start_err;
  logic [9:0]  a_row;
  logic [10:0] a_col;
  logic [1:0]  a_mode_q;
  logic [17:0] a_pair_count;

  logic        b_pix_valid, b_hsync, b_line_last, b_frame_last, b_busy, b_ctrl_done, b_start_err;
  logic [9:0]  b_row;
  logic [10:0] b_col;
  logic [1:0]  b_mode_q;
  logic [17:0] b_pair_count;

  image_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB)) dut_a (
    .HCLK(clk), .HRESETn(rst_n), .start(start_a), .abort(abort_a), .mode_in(mode_a),
    .pix_ready(ready_a), .pix_valid(a_pix_valid), .row(a_row), .col(a_col), .HSYNC(a_hsync),
    .line_last(a_line_last), .frame_last(a_frame_last), .mode_q(a_mode_q), .busy(a_busy),
    .pair_count(a_pair_count), .ctrl_done(a_ctrl_done), .start_err(a_start_err)
  );

  image_frame_sequencer #(.WIDTH(BW), .HEIGHT(BH), .HBLANK(BHB)) dut_b (
    .HCLK(clk), .HRESETn(rst_n), .start(start_b), .abort(abort_b), .mode_in(mode_b),
    .pix_ready(ready_b), .pix_valid(b_pix_valid), .row(b_row), .col(b_col), .HSYNC(b_hsync),
    .line_last(b_line_last), .frame_last(b_frame_last), .mode_q(b_mode_q), .busy(b_busy),
    .pair_count(b_pair_count), .ctrl_done(b_ctrl_done), .start_err(b_start_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct { int row; int col; } pair_t;
  pair_t exp_q[$];
  int    exp_mode;
  bit    mon_en, prev_last, held;
  int    held_row, held_col;
  int    ready_policy;  // 0 manual, 1 alternate, 2 random
  pair_t e;

  // Expected pair order for one frame: raster order, two pixels per pair.
  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c += 2) exp_q.push_back('{r, c});
  endtask

  // Cycle k counts from the cycle in which start is high.
  function automatic void frame_model(input int k, input int w, input int h, input int hb,
                                      output bit v, output int ln, output int ps);
    int per;
    per = w / 2 + hb;
    v = 1'b0; ln = 0; ps = 0;
    if (k >= 1) begin
      ln = (k - 1) / per;
      ps = (k - 1) % per;
      v  = (ln < h) && (ps < w / 2);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_policy)
      1: ready_a = ~ready_a;
      2: ready_a = ($urandom_range(99) < 70);
      default: ;
    endcase
  endtask

  task automatic start_frame(input logic [1:0] m);
    mode_a = m;
    exp_mode = m;
    push_frame();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!a_busy) break;
    end
    check(name, a_busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_row"}, a_row, 0);
    check({name, "_col"}, a_col, 0);
    check({name, "_pair_count"}, a_pair_count, 0);
    check({name, "_mode_q"}, a_mode_q, 0);
    check({name, "_pix_valid"}, a_pix_valid, 0);
    check({name, "_hsync"}, a_hsync, 0);
    check({name, "_ctrl_done"}, a_ctrl_done, 0);
    check({name, "_start_err"}, a_start_err, 0);
    check({name, "_busy"}, a_busy, 0);
  endtask

  // Monitor: pops one expected pair per accepted transfer, checks stall stability and done timing.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ctrl_done_after_last", a_ctrl_done, prev_last);
      prev_last = 1'b0;
      if (held && a_pix_valid) begin
        check("stall_row", a_row, held_row);
        check("stall_col", a_col, held_col);
      end
      held     = a_pix_valid && !ready_a;
      held_row = a_row;
      held_col = a_col;
      if (a_pix_valid && ready_a && !abort_a && rst_n) begin
        if (exp_q.size() == 0) begin
          check("xfer_without_expected_pair", a_pix_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("xfer_row", a_row, e.row);
          check("xfer_col", a_col, e.col);
          check("xfer_mode_q", a_mode_q, exp_mode);
          check("xfer_line_last", a_line_last, e.col == W - 2);
          check("xfer_frame_last", a_frame_last, (e.col == W - 2) && (e.row == H - 1));
          prev_last = (exp_q.size() == 0);
        end
      end
    end
  end

  initial begin
    bit v;
    int ln, ps;

    rst_n = 1'b0; start_a = 1'b1; abort_a = 1'b0; mode_a = 2'b11; ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 2'b00; ready_b = 1'b1;
    ready_policy = 0; mon_en = 1'b0; prev_last = 1'b0; held = 1'b0; exp_mode = 0;
    repeat (3) tick();
    check_all_zero("reset");
    start_a = 1'b0;
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Directed frame, ready high, with a stray start during line 0.
    mode_a = 2'b10; exp_mode = 2; push_frame(); start_a = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      frame_model(k, W, H, HB, v, ln, ps);
      check("t1_pix_valid", a_pix_valid, v);
      check("t1_hsync", a_hsync, v);
      check("t1_ctrl_done", a_ctrl_done, k == DONE_A);
      check("t1_start_err", a_start_err, k == 4);
      if (v) begin
        check("t1_row", a_row, ln);
        check("t1_col", a_col, 2 * ps);
      end
      if (k == DONE_A) check("t1_pair_count", a_pair_count, W * H / 2);
      if (k == 25) check("t1_busy_after", a_busy, 0);
      tick();
      start_a = (k + 1 == 3);
    end
    check("t1_queue_drained", exp_q.size(), 0);

    // Alternating backpressure.
    ready_a = 1'b1; ready_policy = 1;
    start_frame(2'b00);
    wait_idle(200, "t2_timeout");
    ready_policy = 0; ready_a = 1'b1;
    check("t2_queue_drained", exp_q.size(), 0);
    check("t2_pair_count", a_pair_count, W * H / 2);

    // No-blank configuration on the second instance.
    start_b = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      frame_model(k, BW, BH, BHB, v, ln, ps);
      check("t3_pix_valid", b_pix_valid, v);
      check("t3_hsync", b_hsync, v);
      check("t3_ctrl_done", b_ctrl_done, k == DONE_B);
      if (v) begin
        check("t3_row", b_row, ln);
        check("t3_col", b_col, 2 * ps);
      end
      tick();
      start_b = 1'b0;
    end
    check("t3_pair_count", b_pair_count, BW * BH / 2);

    // mode_in changed mid-frame must not reach mode_q.
    start_frame(2'b11);
    repeat (6) tick();
    mode_a = 2'b01;
    wait_idle(200, "t4_timeout");
    check("t4_mode_held", a_mode_q, 3);
    start_frame(2'b01);
    check("t4_mode_relatched", a_mode_q, 1);
    wait_idle(200, "t4b_timeout");

    // Abort on the second line after five transfers.
    start_frame(2'b00);
    repeat (7) tick();
    abort_a = 1'b1; ready_a = 1'b0;
    tick();
    abort_a = 1'b0; ready_a = 1'b1;
    check("t5_busy", a_busy, 0);
    check("t5_pix_valid", a_pix_valid, 0);
    check("t5_pair_count", a_pair_count, 5);
    exp_q.delete();
    repeat (2) tick();
    check("t5_no_done", a_ctrl_done, 0);
    abort_a = 1'b1; start_a = 1'b1;
    tick();
    abort_a = 1'b0; start_a = 1'b0;
    check("t5_abort_beats_start", a_busy, 0);
    check("t5_pair_count_frozen", a_pair_count, 5);

    // Reset mid-frame.
    start_frame(2'b10);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("t7_reset");
    rst_n = 1'b1;
    exp_q.delete();
    tick();

    // Randomized frames with random backpressure and modes.
    ready_policy = 2;
    for (int f = 0; f < 6; f++) begin
      start_frame(2'($urandom_range(3)));
      wait_idle(400, "t8_timeout");
      check("t8_queue_drained", exp_q.size(), 0);
      check("t8_pair_count", a_pair_count, W * H / 2);
      repeat ($urandom_range(3)) tick();
    end
    ready_policy = 0;
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
